// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Number of words in the data memory
    localparam int DMEM_DEPTH = 32;

    // Requester indices
    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin against the previous winner, or fixed
// priority to port 0. Purely combinational; the history bit lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic [1:0] win
);

    // One-hot winner; on contention port 0 wins if fixed or if port 1 won last
    always_comb begin
        win = 2'b00;
        unique case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = (fixed || last) ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU and loader/debug accesses onto a single-port data memory.
// Each access takes IDLE -> ACCESS -> RESP; strobes are only active in ACCESS.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH      = DMEM_DEPTH,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        we_l_q, we_l_d;
    logic [31:0] addr_l_q, addr_l_d;
    logic [31:0] wdata_l_q, wdata_l_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [1:0]  win;
    logic        in_range;
    logic        in_access;

    rr_arb2 u_arb (
        .req   (req),
        .last  (last_q),
        .fixed (FIXED_PRIO),
        .win   (win)
    );

    // Unsigned compare, so 0xFFFFFFFF is out of range
    assign in_range  = (addr_l_q < DEPTH_W);
    assign in_access = (state_q == ACCESS);

    // Next-state logic: arbitrate in IDLE, perform the access, then respond
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        we_l_d    = we_l_q;
        addr_l_d  = addr_l_q;
        wdata_l_d = wdata_l_q;
        gnt_d     = 2'b00;
        rvalid_d  = 2'b00;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d   = win[PORT_DBG];
                    last_d    = win[PORT_DBG];
                    we_l_d    = win[PORT_DBG] ? we[PORT_DBG] : we[PORT_CPU];
                    addr_l_d  = win[PORT_DBG] ? addr1 : addr0;
                    wdata_l_d = win[PORT_DBG] ? wdata1 : wdata0;
                    gnt_d     = win;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d  = (in_range && !we_l_q) ? mem_rdata : 32'h0;
                err_d    = !in_range;
                rvalid_d = owner_q ? 2'b10 : 2'b01;
                state_d  = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers; reset makes port 0 the first round-robin winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            we_l_q    <= 1'b0;
            addr_l_q  <= 32'h0;
            wdata_l_q <= 32'h0;
            gnt_q     <= 2'b00;
            rvalid_q  <= 2'b00;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            we_l_q    <= we_l_d;
            addr_l_q  <= addr_l_d;
            wdata_l_q <= wdata_l_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Memory strobes derive from registered state so reset drops them at once
    always_comb begin
        mem_re    = in_access && in_range && !we_l_q;
        mem_we    = in_access && in_range && we_l_q;
        mem_addr  = (in_access && in_range) ? addr_l_q : 32'h0;
        mem_wdata = (in_access && in_range) ? wdata_l_q : 32'h0;
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign err    = err_q;
    assign busy   = (state_q != IDLE);

endmodule
